// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Glyph constants are active-low (0 = lit), bit0 = segment a .. bit6 = segment g.
// Used by seg_lut, decoder and the units/tens display wrapper.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_lut.sv
// Combinational 4-bit code to active-low seven-segment lookup.
// Ports:
//   code_i : 4-bit unsigned code 0-15
//   seg_o  : active-low segment pattern, bit0 = a .. bit6 = g
// Parameter HEX_EN: 0 blanks codes 10-15, 1 shows A,b,C,d,E,F.
module seg_lut
  import seg_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] code_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      4'd10:   seg_o = HEX_EN ? SEG_A : SEG_BLANK;
      4'd11:   seg_o = HEX_EN ? SEG_B : SEG_BLANK;
      4'd12:   seg_o = HEX_EN ? SEG_C : SEG_BLANK;
      4'd13:   seg_o = HEX_EN ? SEG_D : SEG_BLANK;
      4'd14:   seg_o = HEX_EN ? SEG_E : SEG_BLANK;
      4'd15:   seg_o = HEX_EN ? SEG_F : SEG_BLANK;
      // X/Z codes land here in simulation; never show a lit glyph for them.
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Registered seven-segment decoder, one cycle latency.
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset, loads blank
//   bcd_input      : 4-bit unsigned code 0-15
//   seven_segments : segment drive, bit0 = a .. bit6 = g
// Parameters:
//   ACTIVE_LOW : 1 -> lit segment is 0, 0 -> lit segment is 1
//   HEX_EN     : 0 -> codes 10-15 blank, 1 -> hex glyphs
module decoder
  import seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_input,
  output logic [6:0] seven_segments
);

  seg_t lut_seg;
  seg_t seg_d, seg_q;
  seg_t blank;

  seg_lut #(
    .HEX_EN (HEX_EN)
  ) u_seg_lut (
    .code_i (bcd_input),
    .seg_o  (lut_seg)
  );

  // The lookup is active-low; flip both the glyph and blank for active-high panels.
  always_comb begin
    seg_d = ACTIVE_LOW ? lut_seg : ~lut_seg;
    blank = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= blank;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seven_segments = seg_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder. Four instances cover every
// ACTIVE_LOW/HEX_EN combination and share clock, reset and input.
//   cfg0: ACTIVE_LOW=1 HEX_EN=0   cfg1: ACTIVE_LOW=1 HEX_EN=1
//   cfg2: ACTIVE_LOW=0 HEX_EN=0   cfg3: ACTIVE_LOW=0 HEX_EN=1
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd_input;
  logic [6:0] dut_out [4];

  int n_tests = 0;
  int n_fail  = 0;

  bit cfg_al  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit cfg_hex [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // Reference glyphs: active-low, lit segments as listed for codes 0-15 in hex mode.
  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bcd_input(bcd_input), .seven_segments(dut_out[0]));
  decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bcd_input(bcd_input), .seven_segments(dut_out[1]));
  decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .bcd_input(bcd_input), .seven_segments(dut_out[2]));
  decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_dut3 (
    .clk(clk), .rst(rst), .bcd_input(bcd_input), .seven_segments(dut_out[3]));

  // Expected output for a given config after an edge that sampled (code, reset).
  function automatic logic [6:0] model(int code, bit was_rst, bit al, bit hex);
    logic [6:0] g;
    if (was_rst || (code >= 10 && !hex)) g = 7'h7F;
    else g = glyph_tab[code];
    return al ? g : ~g;
  endfunction

  // Apply inputs, pass one rising edge, sample 1 time unit later.
  task automatic step(input logic [3:0] code, input logic r);
    bcd_input = code;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    step(4'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp = model(8, 1'b1, cfg_al[i], cfg_hex[i]);
      n_tests++;
      if (dut_out[i] !== exp) begin
        n_fail++;
        $display("FAIL reset_blank cfg%0d: got %h expected %h", i, dut_out[i], exp);
      end
    end
    step(4'd8, 1'b0);
    n_tests++;
    if (dut_out[0] !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_release cfg0: got %h expected %h", dut_out[0], 7'h00);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] exp;
    for (int c = 0; c < 16; c++) begin
      step(4'(c), 1'b0);
      for (int i = 0; i < 4; i++) begin
        exp = model(c, 1'b0, cfg_al[i], cfg_hex[i]);
        n_tests++;
        if (dut_out[i] !== exp) begin
          n_fail++;
          $display("FAIL sweep code%0d cfg%0d: got %h expected %h", c, i, dut_out[i], exp);
        end
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] hex_exp [6] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int c = 10; c < 16; c++) begin
      step(4'(c), 1'b0);
      n_tests++;
      if (dut_out[1] !== hex_exp[c-10]) begin
        n_fail++;
        $display("FAIL hex code%0d: got %h expected %h", c, dut_out[1], hex_exp[c-10]);
      end
    end
  endtask

  task automatic test_active_low();
    step(4'd1, 1'b0);
    n_tests++;
    if (dut_out[2] !== 7'h06) begin
      n_fail++;
      $display("FAIL active_high_one: got %h expected %h", dut_out[2], 7'h06);
    end
    step(4'd1, 1'b1);
    n_tests++;
    if (dut_out[2] !== 7'h00) begin
      n_fail++;
      $display("FAIL active_high_reset: got %h expected %h", dut_out[2], 7'h00);
    end
  endtask

  task automatic test_zero_ext();
    logic       tens;
    logic [6:0] exp [2] = '{7'h40, 7'h79};
    for (int b = 0; b < 2; b++) begin
      tens = b[0];
      step({3'b000, tens}, 1'b0);
      n_tests++;
      if (dut_out[0] !== exp[b]) begin
        n_fail++;
        $display("FAIL zero_ext bit%0d: got %h expected %h", b, dut_out[0], exp[b]);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(4'd3, 1'b0);
    n_tests++;
    if (dut_out[0] !== 7'h30) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got %h expected %h", dut_out[0], 7'h30);
    end
    step(4'd4, 1'b1);
    n_tests++;
    if (dut_out[0] !== 7'h7F) begin
      n_fail++;
      $display("FAIL mid_reset_blank: got %h expected %h", dut_out[0], 7'h7F);
    end
  endtask

  // Random codes every cycle with occasional reset; each edge checked against the model.
  task automatic test_back_to_back();
    int         code;
    bit         r;
    logic [6:0] exp;
    for (int n = 0; n < 300; n++) begin
      code = int'($urandom_range(0, 15));
      r    = ($urandom_range(0, 15) == 0);
      step(4'(code), r);
      for (int i = 0; i < 4; i++) begin
        exp = model(code, r, cfg_al[i], cfg_hex[i]);
        n_tests++;
        if (dut_out[i] !== exp) begin
          n_fail++;
          $display("FAIL b2b n%0d code%0d rst%0d cfg%0d: got %h expected %h",
                   n, code, r, i, dut_out[i], exp);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bcd_input = 4'd0;
    #2;
    test_reset();
    test_sweep();
    test_hex();
    test_active_low();
    test_zero_ext();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
